spi_reg_bridge: RTL and testbench

- Parametrised successor to the single-word SPI bus FSM between spi_slave and the pmsre register file.
- Decodes an SPI byte stream into register-bus read/write strobes.
- Configurable data-word width (bytes per word) and address width.
- Adds burst auto-increment with read prefetch, and abort detection when chip-select drops mid-word.

---
 rtl/pmsre_pkg.sv | 17 +
 rtl/spi_word_shifter.sv | 45 ++++
 rtl/spi_reg_bridge.sv | 141 ++++++++++++++
 tb/tb_spi_reg_bridge.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmsre_pkg.sv
// Shared types and constants for the SPI byte-stream to register-bus bridge.
package pmsre_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_FETCH,
    RD_CAP,
    RD_DATA,
    HOLD
  } state_t;

  localparam int         CMD_RW_BIT    = 7;
  localparam logic [7:0] SPI_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_word_shifter.sv
// DATA_BYTES-deep byte shift register, MSB byte first, with a byte counter.
// Used both to assemble received write words and to serialise read words.
module spi_word_shifter #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    shift,
  input  logic [8*DATA_BYTES-1:0] load_word,
  input  logic [7:0]              shift_in,
  output logic [8*DATA_BYTES-1:0] word,
  output logic [7:0]              msb,
  output logic                    busy,
  output logic                    last
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);

  logic [CW-1:0] cnt;

  assign msb  = word[W-1 -: 8];
  assign busy = (cnt != '0);
  // High while the next shift completes a whole word.
  assign last = (cnt == CW'(DATA_BYTES - 1));

  // clr only drops the count; stale word bits are overwritten by the next full word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      word <= load_word;
      cnt  <= '0;
    end else if (shift) begin
      word <= (word << 8) | W'(shift_in);
      cnt  <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes an SPI byte stream (command byte + MSB-first data words) into
// register-bus read/write strobes, with burst auto-increment and read prefetch.
module spi_reg_bridge
  import pmsre_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_BYTES = 4,
  parameter int BURST_EN   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_sel,
  input  logic                    spi_valid,
  input  logic [7:0]              spi_rx,
  output logic [7:0]              spi_tx,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  output logic                    bus_write,
  output logic                    bus_read,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  output logic                    abort
);

  localparam int W = 8 * DATA_BYTES;

  state_t         state, state_nxt;
  logic           clr, rx_shift, tx_load, tx_shift;
  logic           addr_ld, addr_inc, wr_go, wr_pend, abort_nxt;
  logic [W-1:0]   rx_word, tx_word_unused;
  logic [7:0]     rx_msb_unused, tx_msb;
  logic           rx_busy, rx_last, tx_busy, tx_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    rx_shift  = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    addr_ld   = 1'b0;
    addr_inc  = 1'b0;
    wr_go     = 1'b0;
    abort_nxt = 1'b0;
    if (!spi_sel) begin
      // Deselect beats any byte arriving in the same cycle.
      state_nxt = IDLE;
      clr       = 1'b1;
      abort_nxt = (state == WR_DATA && rx_busy) || (state == RD_DATA && tx_busy);
    end else begin
      case (state)
        IDLE: state_nxt = CMD;
        CMD: if (spi_valid) begin
          addr_ld   = 1'b1;
          state_nxt = spi_rx[CMD_RW_BIT] ? RD_FETCH : WR_DATA;
        end
        WR_DATA: if (spi_valid) begin
          rx_shift = 1'b1;
          if (rx_last) begin
            wr_go = 1'b1;
            if (BURST_EN == 0) state_nxt = HOLD;
          end
        end
        RD_FETCH: state_nxt = RD_CAP;
        RD_CAP: begin
          tx_load   = 1'b1;
          state_nxt = RD_DATA;
        end
        RD_DATA: if (spi_valid) begin
          tx_shift = 1'b1;
          if (tx_last) begin
            if (BURST_EN != 0) begin
              addr_inc  = 1'b1;
              state_nxt = RD_FETCH;
            end else begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD:    state_nxt = HOLD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Word completes -> wdata loads -> strobe, so data and address are stable under bus_write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_write <= 1'b0;
      bus_read  <= 1'b0;
      abort     <= 1'b0;
      wr_pend   <= 1'b0;
    end else begin
      wr_pend   <= wr_go;
      bus_write <= wr_pend;
      bus_read  <= (state_nxt == RD_FETCH);
      abort     <= abort_nxt;
      if (wr_pend) bus_wdata <= rx_word;
      if (addr_ld)
        bus_addr <= spi_rx[ADDR_W-1:0];
      else if (addr_inc || (bus_write && BURST_EN != 0))
        bus_addr <= bus_addr + ADDR_W'(1);
    end
  end

  assign spi_tx = (state == RD_DATA) ? tx_msb : SPI_IDLE_BYTE;

  spi_word_shifter #(.DATA_BYTES(DATA_BYTES)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .load      (1'b0),
    .shift     (rx_shift),
    .load_word ('0),
    .shift_in  (spi_rx),
    .word      (rx_word),
    .msb       (rx_msb_unused),
    .busy      (rx_busy),
    .last      (rx_last)
  );

  spi_word_shifter #(.DATA_BYTES(DATA_BYTES)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .load      (tx_load),
    .shift     (tx_shift),
    .load_word (bus_rdata),
    .shift_in  (SPI_IDLE_BYTE),
    .word      (tx_word_unused),
    .msb       (tx_msb),
    .busy      (tx_busy),
    .last      (tx_last)
  );

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench: a burst bridge and a single-word bridge share the SPI stimulus.
module tb_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0, valid = 1'b0, tgt = 1'b0;
  logic [7:0]  rx = 8'h00;
  logic        sel_b, sel_n;
  int          errors = 0, checks = 0, pat = 0;

  logic [7:0]  b_tx, n_tx;
  logic [6:0]  b_addr, n_addr;
  logic [31:0] b_wdata, n_wdata, b_rdata = '0, n_rdata = '0;
  logic        b_write, n_write, b_read, n_read, b_abort, n_abort;

  always #5 clk = ~clk;

  assign sel_b = sel & ~tgt;
  assign sel_n = sel & tgt;

  spi_reg_bridge #(.ADDR_W(7), .DATA_BYTES(4), .BURST_EN(1)) u_dut (
    .clk(clk), .reset(reset), .spi_sel(sel_b), .spi_valid(valid), .spi_rx(rx),
    .spi_tx(b_tx), .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_write(b_write),
    .bus_read(b_read), .bus_rdata(b_rdata), .abort(b_abort)
  );

  spi_reg_bridge #(.ADDR_W(7), .DATA_BYTES(4), .BURST_EN(0)) u_nb (
    .clk(clk), .reset(reset), .spi_sel(sel_n), .spi_valid(valid), .spi_rx(rx),
    .spi_tx(n_tx), .bus_addr(n_addr), .bus_wdata(n_wdata), .bus_write(n_write),
    .bus_read(n_read), .bus_rdata(n_rdata), .abort(n_abort)
  );

  function automatic logic [31:0] rd_model(input logic [6:0] a, input int p);
    logic [7:0] x;
    x = {1'b0, a};
    if (p == 0) return {x, x, x, x};
    return {x ^ 8'h11, x ^ 8'h22, x ^ 8'h33, x ^ 8'h44};
  endfunction

  // Register file model: read data valid the cycle after bus_read.
  always @(posedge clk) begin
    if (b_read) b_rdata <= rd_model(b_addr, pat);
    if (n_read) n_rdata <= rd_model(n_addr, pat);
  end

  logic [39:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  int          wr_cnt[2] = '{0, 0};
  int          ab_cnt[2] = '{0, 0};
  logic [1:0]  m_write, m_read, m_abort;
  logic [6:0]  m_addr[2];
  logic [31:0] m_wdata[2];
  logic [39:0] mw_got, mw_exp;
  logic [7:0]  mr_got, mr_exp;

  assign m_write = {n_write, b_write};
  assign m_read  = {n_read, b_read};
  assign m_abort = {n_abort, b_abort};
  assign m_addr[0] = b_addr;
  assign m_addr[1] = n_addr;
  assign m_wdata[0] = b_wdata;
  assign m_wdata[1] = n_wdata;

  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        if (m_write[d] || m_read[d]) begin
          checks++;
          if (m_write[d] && m_read[d]) begin
            errors++;
            $display("FAIL strobe_overlap dut%0d: write=1 read=1, required at most one", d);
          end
        end
        if (m_write[d]) begin
          wr_cnt[d]++;
          checks++;
          mw_got = {1'(d), m_addr[d], m_wdata[d]};
          if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write dut%0d: got %h, required no write", d, mw_got);
          end else begin
            mw_exp = exp_wr.pop_front();
            if (mw_got !== mw_exp) begin
              errors++;
              $display("FAIL write dut%0d: got {dut,addr,data}=%h required %h", d, mw_got, mw_exp);
            end
          end
        end
        if (m_read[d]) begin
          checks++;
          mr_got = {1'(d), m_addr[d]};
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read dut%0d: got %h, required no read", d, mr_got);
          end else begin
            mr_exp = exp_rd.pop_front();
            if (mr_got !== mr_exp) begin
              errors++;
              $display("FAIL read dut%0d: got {dut,addr}=%h required %h", d, mr_got, mr_exp);
            end
          end
        end
        if (m_abort[d]) ab_cnt[d]++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One byte slot: idle gap, sample spi_tx, then a single-cycle valid.
  task automatic send(input logic [7:0] b, output logic [7:0] txs);
    repeat (15) tick();
    txs = tgt ? n_tx : b_tx;
    rx = b;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic start_frame(input logic t);
    tgt = t;
    sel = 1'b1;
    repeat (3) tick();
  endtask

  task automatic end_frame;
    repeat (20) tick();
    sel = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    #23;
    checks++; if (b_tx !== 8'h00)   begin errors++; $display("FAIL reset_tx: got %h required 00", b_tx); end
    checks++; if (b_addr !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h required 00", b_addr); end
    checks++; if (b_wdata !== '0)   begin errors++; $display("FAIL reset_wdata: got %h required 0", b_wdata); end
    checks++; if ({b_write, b_read, b_abort} !== 3'b000)
      begin errors++; $display("FAIL reset_strobes: got %b required 000", {b_write, b_read, b_abort}); end
    checks++; if ({n_write, n_read, n_abort, n_tx} !== 11'h0)
      begin errors++; $display("FAIL reset_nb: got %h required 0", {n_write, n_read, n_abort, n_tx}); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_write;
    logic [7:0] d[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] txs;
    int w0 = wr_cnt[0], a0 = ab_cnt[0];
    exp_wr.push_back({1'b0, 7'h05, 32'h12345678});
    start_frame(1'b0);
    send(8'h05, txs);
    checks++; if (txs !== 8'h00) begin errors++; $display("FAIL cmd_tx: got %h required 00", txs); end
    for (int i = 0; i < 4; i++) send(d[i], txs);
    end_frame();
    checks++; if (wr_cnt[0] - w0 != 1) begin errors++; $display("FAIL write_count: got %0d required 1", wr_cnt[0] - w0); end
    checks++; if (ab_cnt[0] != a0) begin errors++; $display("FAIL write_abort: got %0d pulses required 0", ab_cnt[0] - a0); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL write_pending: got %0d left required 0", exp_wr.size()); end
  endtask

  task automatic read_frame(input logic [6:0] a, input int p, input int nbytes);
    logic [7:0]  txs, eb;
    logic [31:0] w;
    pat = p;
    start_frame(1'b0);
    send({1'b1, a}, txs);
    for (int i = 0; i < nbytes; i++) begin
      send(8'h00, txs);
      w = rd_model(7'(a + 7'(i / 4)), p);
      eb = w[31 - 8 * (i % 4) -: 8];
      checks++;
      if (txs !== eb) begin errors++; $display("FAIL read_tx addr %h byte %0d: got %h required %h", a, i, txs, eb); end
    end
    end_frame();
  endtask

  task automatic test_burst_read;
    int a0 = ab_cnt[0];
    exp_rd.push_back({1'b0, 7'd3});
    exp_rd.push_back({1'b0, 7'd4});
    exp_rd.push_back({1'b0, 7'd5});
    read_frame(7'd3, 0, 8);
    exp_rd.push_back({1'b0, 7'h10});
    exp_rd.push_back({1'b0, 7'h11});
    read_frame(7'h10, 1, 4);
    checks++; if (exp_rd.size() != 0) begin errors++; $display("FAIL burst_read_pending: got %0d left required 0", exp_rd.size()); end
    checks++; if (b_tx !== 8'h00) begin errors++; $display("FAIL idle_tx: got %h required 00", b_tx); end
    checks++; if (ab_cnt[0] != a0) begin errors++; $display("FAIL read_abort: got %0d pulses required 0", ab_cnt[0] - a0); end
  endtask

  task automatic test_wrap;
    logic [7:0] d[8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
    logic [7:0] txs;
    exp_wr.push_back({1'b0, 7'h7F, 32'hDEADBEEF});
    exp_wr.push_back({1'b0, 7'h00, 32'h0BADF00D});
    start_frame(1'b0);
    send(8'h7F, txs);
    for (int i = 0; i < 8; i++) send(d[i], txs);
    end_frame();
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL wrap_pending: got %0d left required 0", exp_wr.size()); end
  endtask

  task automatic test_abort;
    logic [7:0] txs;
    int w0 = wr_cnt[0], a0 = ab_cnt[0];
    start_frame(1'b0);
    send(8'h02, txs);
    send(8'hAA, txs);
    send(8'hBB, txs);
    end_frame();
    checks++; if (ab_cnt[0] - a0 != 1) begin errors++; $display("FAIL abort_pulse: got %0d pulses required 1", ab_cnt[0] - a0); end
    checks++; if (wr_cnt[0] != w0) begin errors++; $display("FAIL abort_nowrite: got %0d writes required 0", wr_cnt[0] - w0); end
    exp_wr.push_back({1'b0, 7'h06, 32'h01020304});
    start_frame(1'b0);
    send(8'h06, txs);
    for (int i = 1; i <= 4; i++) send(8'(i), txs);
    end_frame();
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL after_abort_pending: got %0d left required 0", exp_wr.size()); end
    checks++; if (ab_cnt[0] - a0 != 1) begin errors++; $display("FAIL after_abort_pulse: got %0d pulses required 1", ab_cnt[0] - a0); end
    exp_rd.push_back({1'b0, 7'h08});
    read_frame(7'h08, 0, 2);
    checks++; if (ab_cnt[0] - a0 != 2) begin errors++; $display("FAIL read_abort_pulse: got %0d pulses required 2", ab_cnt[0] - a0); end
    checks++; if (exp_rd.size() != 0) begin errors++; $display("FAIL read_abort_pending: got %0d left required 0", exp_rd.size()); end
  endtask

  task automatic test_no_burst;
    logic [7:0] txs, eb;
    int w0 = wr_cnt[0], n0 = wr_cnt[1], a1 = ab_cnt[1];
    exp_wr.push_back({1'b1, 7'h01, 32'h11223344});
    start_frame(1'b1);
    send(8'h01, txs);
    for (int i = 1; i <= 8; i++) send(8'(i * 16 + i), txs);
    end_frame();
    checks++; if (wr_cnt[1] - n0 != 1) begin errors++; $display("FAIL nb_write_count: got %0d required 1", wr_cnt[1] - n0); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL nb_write_pending: got %0d left required 0", exp_wr.size()); end
    pat = 0;
    exp_rd.push_back({1'b1, 7'h05});
    start_frame(1'b1);
    send(8'h85, txs);
    for (int i = 0; i < 6; i++) begin
      send(8'h00, txs);
      eb = (i < 4) ? 8'h05 : 8'h00;
      checks++;
      if (txs !== eb) begin errors++; $display("FAIL nb_read_tx byte %0d: got %h required %h", i, txs, eb); end
    end
    end_frame();
    checks++; if (exp_rd.size() != 0) begin errors++; $display("FAIL nb_read_pending: got %0d left required 0", exp_rd.size()); end
    checks++; if (ab_cnt[1] != a1) begin errors++; $display("FAIL nb_abort: got %0d pulses required 0", ab_cnt[1] - a1); end
    checks++; if (wr_cnt[0] != w0) begin errors++; $display("FAIL nb_isolation: got %0d burst writes required 0", wr_cnt[0] - w0); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] txs;
    int a0 = ab_cnt[0];
    start_frame(1'b0);
    send(8'h04, txs);
    send(8'hC1, txs);
    send(8'hC2, txs);
    repeat (5) tick();
    checks++; if (b_addr !== 7'h04) begin errors++; $display("FAIL pre_reset_addr: got %h required 04", b_addr); end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (b_addr !== 7'h00) begin errors++; $display("FAIL async_addr: got %h required 00", b_addr); end
    checks++; if (b_wdata !== '0) begin errors++; $display("FAIL async_wdata: got %h required 0", b_wdata); end
    checks++; if ({b_tx, b_write, b_read, b_abort} !== 11'h0)
      begin errors++; $display("FAIL async_rest: got %h required 0", {b_tx, b_write, b_read, b_abort}); end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();
    exp_wr.push_back({1'b0, 7'h04, 32'hA1A2A3A4});
    start_frame(1'b0);
    send(8'h04, txs);
    for (int i = 1; i <= 4; i++) send(8'(8'hA0 + i), txs);
    end_frame();
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL post_reset_pending: got %0d left required 0", exp_wr.size()); end
    checks++; if (ab_cnt[0] != a0) begin errors++; $display("FAIL post_reset_abort: got %0d pulses required 0", ab_cnt[0] - a0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_read();
    test_wrap();
    test_abort();
    test_no_burst();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
